// File: rtl/spart_key_pkg.sv
// ---------------------------------------------------------------------------
// spart_key_pkg
// Shared definitions for the SPART keyboard controller:
//   - key word type and bit positions of each game key
//   - delivery FSM state type
//   - decode_key(): case-insensitive ASCII -> one-hot key word
// No ports (package).
// ---------------------------------------------------------------------------
package spart_key_pkg;

  localparam int KEY_W = 13;

  // Bit position of each key inside the 13-bit one-hot word
  localparam int KEY_BIT_W = 12;
  localparam int KEY_BIT_S = 11;
  localparam int KEY_BIT_A = 10;
  localparam int KEY_BIT_D = 9;
  localparam int KEY_BIT_Q = 8;
  localparam int KEY_BIT_E = 7;
  localparam int KEY_BIT_I = 6;
  localparam int KEY_BIT_K = 5;
  localparam int KEY_BIT_J = 4;
  localparam int KEY_BIT_L = 3;
  localparam int KEY_BIT_U = 2;
  localparam int KEY_BIT_O = 1;
  localparam int KEY_BIT_R = 0;

  typedef logic [KEY_W-1:0] key_word_t;

  localparam key_word_t KEY_NONE = 13'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } dlv_state_t;

  // Upper-case letters are folded to lower case before lookup; anything
  // outside the key set decodes to KEY_NONE.
  function automatic key_word_t decode_key(input logic [7:0] ascii);
    logic [7:0] lc;
    key_word_t  key;
    if ((ascii >= 8'h41) && (ascii <= 8'h5A)) begin
      lc = ascii | 8'h20;
    end else begin
      lc = ascii;
    end
    key = KEY_NONE;
    case (lc)
      8'h77:   key[KEY_BIT_W] = 1'b1;
      8'h73:   key[KEY_BIT_S] = 1'b1;
      8'h61:   key[KEY_BIT_A] = 1'b1;
      8'h64:   key[KEY_BIT_D] = 1'b1;
      8'h71:   key[KEY_BIT_Q] = 1'b1;
      8'h65:   key[KEY_BIT_E] = 1'b1;
      8'h69:   key[KEY_BIT_I] = 1'b1;
      8'h6B:   key[KEY_BIT_K] = 1'b1;
      8'h6A:   key[KEY_BIT_J] = 1'b1;
      8'h6C:   key[KEY_BIT_L] = 1'b1;
      8'h75:   key[KEY_BIT_U] = 1'b1;
      8'h6F:   key[KEY_BIT_O] = 1'b1;
      8'h72:   key[KEY_BIT_R] = 1'b1;
      default: key = KEY_NONE;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/spart_key_fifo.sv
// ---------------------------------------------------------------------------
// spart_key_fifo
// Small synchronous FIFO of decoded key words.
//   clk, rst_n  : clock, async active-low reset
//   push        : write push_data (accepted when not full, or full with pop)
//   push_data   : key word to store
//   pop         : remove head entry (ignored when empty)
//   head        : current head entry
//   empty, full : occupancy flags
//   count       : occupancy, 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module spart_key_fifo
  import spart_key_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  key_word_t                     push_data,
  input  logic                          pop,
  output key_word_t                     head,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  key_word_t         mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Occupancy flags and the qualified push/pop strobes
  always_comb begin
    empty     = (count_r == {CW{1'b0}});
    full      = (count_r == CW'(FIFO_DEPTH));
    do_pop_s  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs
    do_push_s = push && (!full || do_pop_s);
    head      = mem_r[rd_ptr_r];
    count     = count_r;
  end

  // Storage, wrapping pointers and saturating occupancy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= KEY_NONE;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spart_key_ctrl.sv
// ---------------------------------------------------------------------------
// spart_key_ctrl
// Turns ASCII bytes from the SPART receiver into one-hot key words, queues
// them, and hands one word to the CPU per key_req poll.
//   clk, rst_n        : clock, async active-low reset
//   rx_data/rx_valid  : byte from receiver; transfers when rx_ready is high
//   rx_ready          : one-entry decode register is empty
//   key_req           : CPU poll strobe (ignored while a delivery is running)
//   SPART_we          : one-cycle pulse, SPART_keys valid while high
//   SPART_keys        : FIFO head key word, or 13'h0000 when nothing queued
//   overflow          : sticky, a mapped key was dropped on a full FIFO
//   fifo_count        : current FIFO occupancy
// Build option: define SPART_KEY_DEBOUNCE_EN to suppress a repeat of the last
// pushed key arriving within DEBOUNCE_CYCLES cycles of that push.
// ---------------------------------------------------------------------------
module spart_key_ctrl
  import spart_key_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  input  logic                          key_req,
  output logic                          SPART_we,
  output logic [KEY_W-1:0]              SPART_keys,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_ready_r;
  logic          dec_full_r;
  logic [7:0]    dec_byte_r;
  key_word_t     dec_key_s;
  logic          suppress_s;
  logic          push_s;
  logic          push_ok_s;
  logic          pop_s;
  key_word_t     head_s;
  logic          empty_s;
  logic          full_s;
  logic [CW-1:0] count_s;
  dlv_state_t    state_r;
  logic          we_r;
  key_word_t     keys_r;
  logic          overflow_r;

  spart_key_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (dec_key_s),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (empty_s),
    .full      (full_s),
    .count     (count_s)
  );

  // Decode the held byte and derive the FIFO push/pop strobes
  always_comb begin
    dec_key_s = decode_key(dec_byte_r);
    push_s    = dec_full_r && (dec_key_s != KEY_NONE) && !suppress_s;
    // The word shown during PRESENT leaves the FIFO at the end of that cycle
    pop_s     = (state_r == ST_PRESENT) && !empty_s;
    push_ok_s = push_s && (!full_s || pop_s);
  end

  // One-entry intake register: a byte is held for exactly one decode cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_r <= 1'b0;
      dec_full_r <= 1'b0;
      dec_byte_r <= 8'h00;
    end else if (rx_valid && rx_ready_r) begin
      rx_ready_r <= 1'b0;
      dec_full_r <= 1'b1;
      dec_byte_r <= rx_data;
    end else begin
      rx_ready_r <= 1'b1;
      dec_full_r <= 1'b0;
      dec_byte_r <= dec_byte_r;
    end
  end

  // Sticky overflow: a mapped key met a full FIFO with no pop to make room
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (push_s && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Delivery FSM with registered pulse and key word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      we_r    <= 1'b0;
      keys_r  <= KEY_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (key_req) begin
            state_r <= ST_PRESENT;
            we_r    <= 1'b1;
            // Show the head as it will be during PRESENT: a key being pushed
            // into an empty FIFO right now becomes that head.
            if (!empty_s) begin
              keys_r <= head_s;
            end else if (push_s) begin
              keys_r <= dec_key_s;
            end else begin
              keys_r <= KEY_NONE;
            end
          end else begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            keys_r  <= KEY_NONE;
          end
        end
        ST_PRESENT: begin
          state_r <= ST_GAP;
          we_r    <= 1'b0;
          keys_r  <= KEY_NONE;
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
          we_r    <= 1'b0;
          keys_r  <= KEY_NONE;
        end
        default: begin
          state_r <= ST_IDLE;
          we_r    <= 1'b0;
          keys_r  <= KEY_NONE;
        end
      endcase
    end
  end

`ifdef SPART_KEY_DEBOUNCE_EN
  key_word_t   last_key_r;
  logic [15:0] db_left_r;

  // Repeat of the last stored key while the window is still open
  always_comb begin
    suppress_s = (db_left_r != 16'd0) && (dec_key_s == last_key_r);
  end

  // Window counter, reloaded on every key actually stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_key_r <= KEY_NONE;
      db_left_r  <= 16'd0;
    end else if (push_ok_s) begin
      last_key_r <= dec_key_s;
      db_left_r  <= 16'(DEBOUNCE_CYCLES);
    end else if (db_left_r != 16'd0) begin
      last_key_r <= last_key_r;
      db_left_r  <= db_left_r - 16'd1;
    end else begin
      last_key_r <= last_key_r;
      db_left_r  <= db_left_r;
    end
  end
`else
  assign suppress_s = 1'b0;
`endif

  assign rx_ready   = rx_ready_r;
  assign SPART_we   = we_r;
  assign SPART_keys = keys_r;
  assign overflow   = overflow_r;
  assign fifo_count = count_s;

endmodule

// File: tb/tb_spart_key_ctrl.sv
// Self-checking bench for spart_key_ctrl: a queue-based reference model is
// compared against the DUT on every falling edge, and directed scenarios pin
// hand-computed key words and counts.
module tb_spart_key_ctrl;

  localparam int DEPTH = 4;
  localparam int DB    = 10;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        key_req;
  logic        SPART_we;
  logic [12:0] SPART_keys;
  logic        overflow;
  logic [2:0]  fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  spart_key_ctrl #(
    .FIFO_DEPTH      (DEPTH),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .key_req    (key_req),
    .SPART_we   (SPART_we),
    .SPART_keys (SPART_keys),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference key map: position in the string gives bit 12 down to bit 0
  function automatic logic [12:0] ref_map(input logic [7:0] b);
    string       keys;
    logic [7:0]  lc;
    logic [12:0] r;
    keys = "wsadqeikjluor";
    lc = (b >= 8'h41 && b <= 8'h5A) ? b + 8'd32 : b;
    r = 13'h0000;
    for (int i = 0; i < 13; i++) begin
      if (keys[i] == lc) r = 13'h1000 >> i;
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [12:0] q[$];
  bit          m_pend = 0;
  logic [7:0]  m_pend_byte = 8'h00;
  bit          m_ovf = 0;
  int          m_phase = 0;      // 0 waiting for poll, 1 presenting, 2 gap
  bit          m_rdy = 0;
  bit          m_we = 0;
  logic [12:0] m_keys = 13'h0000;
  int          m_cyc = 0;
  bit          m_have_last = 0;
  logic [12:0] m_last = 13'h0000;
  int          m_last_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pend = 0; m_ovf = 0; m_phase = 0; m_rdy = 0;
      m_we = 0; m_keys = 13'h0000; m_have_last = 0; m_cyc = 0;
    end else begin
      logic [12:0] k;
      bit          sup;
      m_cyc++;
      if (m_phase == 1 && q.size() > 0) void'(q.pop_front());
      if (m_pend) begin
        k = ref_map(m_pend_byte);
        sup = 0;
`ifdef SPART_KEY_DEBOUNCE_EN
        sup = m_have_last && (k == m_last) && ((m_cyc - m_last_cyc) <= DB);
`endif
        if (k != 13'h0000 && !sup) begin
          if (q.size() < DEPTH) begin
            q.push_back(k);
            m_have_last = 1; m_last = k; m_last_cyc = m_cyc;
          end else begin
            m_ovf = 1;
          end
        end
      end
      m_pend = m_rdy && rx_valid;
      m_pend_byte = rx_data;
      m_rdy = !m_pend;
      if (m_phase == 0) m_phase = key_req ? 1 : 0;
      else if (m_phase == 1) m_phase = 2;
      else m_phase = 0;
      m_we = (m_phase == 1);
      m_keys = (m_phase == 1 && q.size() > 0) ? q[0] : 13'h0000;
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    chk("cmp_rx_ready", rx_ready, m_rdy);
    chk("cmp_we", SPART_we, m_we);
    chk("cmp_keys", SPART_keys, m_keys);
    chk("cmp_count", fifo_count, q.size());
    chk("cmp_overflow", overflow, m_ovf);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (rx_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: rx_ready got %0b expected 1", rx_ready);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic poll(input string name, input logic [12:0] exp);
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    chk({name, "_we"}, SPART_we, 1'b1);
    chk({name, "_keys"}, SPART_keys, exp);
    tick();
    tick();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; key_req = 1'b0;

    // Pin the reference map itself
    chk("map_w", ref_map(8'h77), 13'h1000);
    chk("map_R", ref_map(8'h52), 13'h0001);
    chk("map_x", ref_map(8'h78), 13'h0000);

    repeat (3) tick();
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_we", SPART_we, 1'b0);
    chk("rst_keys", SPART_keys, 13'h0000);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    chk("rel_rx_ready0", rx_ready, 1'b0);
    tick();
    chk("rel_rx_ready1", rx_ready, 1'b1);

    // Single 'w' then poll
    send_byte(8'h77);
    tick();
    chk("w_count", fifo_count, 3'd1);
    poll("w_poll", 13'h1000);
    chk("w_count_after", fifo_count, 3'd0);

    // Poll with empty FIFO
    poll("empty_poll", 13'h0000);
    chk("empty_count", fifo_count, 3'd0);

    // 'A','d','x','R' -> three keys in order
    send_byte(8'h41); send_byte(8'h64); send_byte(8'h78); send_byte(8'h52);
    tick();
    chk("adxr_count", fifo_count, 3'd3);
    poll("adxr_p0", 13'h0400);
    poll("adxr_p1", 13'h0200);
    poll("adxr_p2", 13'h0001);

    // Overflow: q,e,i,k,u into a 4-deep FIFO
    send_byte(8'h71); send_byte(8'h65); send_byte(8'h69);
    send_byte(8'h6B); send_byte(8'h75);
    tick();
    chk("ovf_count", fifo_count, 3'd4);
    chk("ovf_flag", overflow, 1'b1);

    // Push ('r') landing on the same edge as the pop of 'q'
    key_req = 1'b1; rx_data = 8'h72; rx_valid = 1'b1;
    chk("coin_ready", rx_ready, 1'b1);
    tick();
    key_req = 1'b0; rx_valid = 1'b0;
    chk("coin_keys", SPART_keys, 13'h0100);
    tick();
    tick();
    chk("coin_count", fifo_count, 3'd4);
    chk("coin_ovf", overflow, 1'b1);
    poll("wrap_p0", 13'h0080);
    poll("wrap_p1", 13'h0040);
    poll("wrap_p2", 13'h0020);
    poll("wrap_p3", 13'h0001);
    chk("wrap_count", fifo_count, 3'd0);

    // Mixed stream with unmapped bytes
    send_byte(8'h53); send_byte(8'h31); send_byte(8'h6F);
    send_byte(8'h78); send_byte(8'h4C); send_byte(8'h64);
    tick();
    chk("mix_count", fifo_count, 3'd4);
    poll("mix_p0", 13'h0800);
    poll("mix_p1", 13'h0002);
    poll("mix_p2", 13'h0008);
    poll("mix_p3", 13'h0200);

    // Async reset in the middle of a PRESENT pulse
    send_byte(8'h77); send_byte(8'h61);
    tick();
    chk("ar_count_pre", fifo_count, 3'd2);
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    chk("ar_we_pre", SPART_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we_now", SPART_we, 1'b0);
    chk("ar_keys_now", SPART_keys, 13'h0000);
    chk("ar_count_now", fifo_count, 3'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_count_post", fifo_count, 3'd0);
    chk("ar_ovf_post", overflow, 1'b0);
    chk("ar_ready_post", rx_ready, 1'b1);

`ifdef SPART_KEY_DEBOUNCE_EN
    // Repeat suppression window of DB cycles
    send_byte(8'h6A);
    repeat (3) tick();
    send_byte(8'h6A);
    tick();
    chk("db_count1", fifo_count, 3'd1);
    repeat (20) tick();
    send_byte(8'h6A);
    tick();
    chk("db_count2", fifo_count, 3'd2);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
